seven_segment_scan: RTL and testbench
=====================================

Name: seven_segment_scan

Overview:
- Parametrised multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
- Accepts a binary value through a valid/busy handshake and converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Time-multiplexes the digits from a refresh divider. Adds overflow saturation and a blank control.
- Sits between game score/state logic and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- VALUE_W, 14: width of the binary input; legal range 1..32.
- DIV_BITS, 16: refresh divider width; the scan advances one digit every 2^DIV_BITS clocks; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- value  input  VALUE_W  unsigned binary number to display
- value_valid  input  1  load strobe; accepted only while busy=0
- blank  input  1  forces all digits off while high
- busy  output  1  conversion in progress
- overflow  output  1  last accepted value exceeded 10^NUM_DIGITS-1
- display  output  7  segments, active-low, bit6=g .. bit0=a
- digit  output  NUM_DIGITS  digit enables, active-low one-hot; digit[0] is the rightmost (units) digit

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - Divider and scan index are 0; busy=0; overflow=0; BCD display register holds all zeros.
  - digit is all ones and display is 7'b1111111, all registered.
  - Reset aborts any conversion in progress; no partial result is committed.
- Handshake:
  - value_valid=1 with busy=0 at edge N captures value.
  - busy=1 from N+1 through N+VALUE_W inclusive.
  - At edge N+VALUE_W the result commits to the display register and overflow updates; busy=0 from N+VALUE_W+1.
  - value_valid while busy=1 is ignored; no queueing.
  - Back-to-back loads are allowed: the cycle busy falls may accept the next value.
- Conversion:
  - Working BCD register is 4*NUM_DIGITS bits.
  - Each step: add 3 to every nibble >=5, then shift left one bit, bringing in the value MSB first.
  - Any 1 shifted out of the top nibble sets a sticky conversion-overflow flag, which becomes overflow at commit.
  - The display register keeps the previous result until commit, so the display never shows a partial result.
- Overflow display: when overflow=1, every digit shows '-' (7'b0111111).
- Scan:
  - Divider free-runs. When it wraps from all ones to 0, the index increments, wrapping from NUM_DIGITS-1 to 0.
  - digit and display are registered one cycle after the index/data they represent. Digit enable and its segments always change on the same edge.
  - Index 0 selects the units nibble.
- Segment codes, g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, off=1111111
  - Any nibble >9 is unreachable; it is driven off.
- blank=1: digit is all ones on the next edge. Scan and conversion continue unaffected.
- NUM_DIGITS=1: the index stays at 0 and digit[0] is permanently selected unless blank=1.

Optional Feature:
- Macro SEG_LEADING_ZERO_BLANK_EN.
- Defined: any digit above the most significant nonzero digit displays off (1111111). Digit 0 is always shown, so value 0 shows a single '0'. Overflow dashes take precedence over blanking.
- Undefined: all digits show their numeral, including leading zeros.

Test Plan:
- Run with DIV_BITS=2, NUM_DIGITS=4, VALUE_W=14.
- Reset: hold rst 3 cycles -> digit=4'b1111, display=7'b1111111, busy=0. First scan slot after release -> digit=4'b1110, display=7'b1000000.
- Load 1234: pulse value_valid -> busy high for exactly 14 cycles. Then the scan shows digit 1110/0011001 ('4'), 1101/0110000 ('3'), 1011/0100100 ('2'), 0111/1111001 ('1'); overflow=0.
- Overflow: load 12345 -> after commit overflow=1 and all four digits show 0111111. Then load 42 -> overflow=0 and the digits show 2,4,0,0; with the macro defined the upper two digits show 1111111.
- Ignored load: load 5678, then pulse value_valid with 9999 at busy cycle 3 -> the final display is 5678 and busy falls at the original time.
- Reset mid-conversion: load 8765, assert rst at busy cycle 7 -> busy=0 next cycle, display register is zero, and 8765 never appears.
- blank: assert blank for 10 cycles during the 1234 display -> digit=4'b1111 throughout. After release the scan resumes at the index the divider has reached.

Source files
------------

// File: rtl/seven_segment_scan.sv
// Multiplexed common-anode seven-segment driver with a serial double-dabble BCD converter.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.

module seven_segment_scan_lane (
    input  logic [3:0] nibble,
    input  logic       show,
    input  logic       ovf,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        if (ovf) begin
            seg = 7'b0111111;
        end else if (show) begin
            case (nibble)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end
endmodule

module seven_segment_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int DIV_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  value_valid,
    input  logic                  blank,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            display,
    output logic [NUM_DIGITS-1:0] digit
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic [VALUE_W-1:0]            shreg;
    logic [BCD_W-1:0]              bcd_work;
    logic [BCD_W-1:0]              bcd_adj;
    logic [BCD_W-1:0]              bcd_disp;
    logic [BCD_W:0]                bcd_shift;
    logic [CNT_W-1:0]              step_cnt;
    logic                          conv_ovf;
    logic                          last_step;
    logic [DIV_BITS-1:0]           div_cnt;
    logic [IDX_W-1:0]              idx;
    logic [NUM_DIGITS-1:0]         show;
    logic [NUM_DIGITS-1:0][6:0]    seg_all;

    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
    end

    // Top bit of bcd_shift is whatever falls off the most significant nibble.
    assign bcd_shift = {bcd_adj, shreg[VALUE_W-1]};
    assign last_step = (step_cnt == CNT_W'(VALUE_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            overflow <= 1'b0;
            conv_ovf <= 1'b0;
            step_cnt <= '0;
            shreg    <= '0;
            bcd_work <= '0;
            bcd_disp <= '0;
        end else if (!busy) begin
            if (value_valid) begin
                busy     <= 1'b1;
                shreg    <= value;
                bcd_work <= '0;
                conv_ovf <= 1'b0;
                step_cnt <= '0;
            end
        end else begin
            shreg    <= shreg << 1;
            bcd_work <= bcd_shift[BCD_W-1:0];
            conv_ovf <= conv_ovf | bcd_shift[BCD_W];
            step_cnt <= step_cnt + CNT_W'(1);
            if (last_step) begin
                busy     <= 1'b0;
                bcd_disp <= bcd_shift[BCD_W-1:0];
                overflow <= conv_ovf | bcd_shift[BCD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_BITS'(1);
            if (&div_cnt)
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic lz_seen;
    always_comb begin
        lz_seen = 1'b0;
        show    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_seen = lz_seen | (|bcd_disp[4*i +: 4]);
            show[i] = lz_seen || (i == 0);
        end
    end
`else
    assign show = '1;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
        seven_segment_scan_lane u_lane (
            .nibble (bcd_disp[4*g +: 4]),
            .show   (show[g]),
            .ovf    (overflow),
            .seg    (seg_all[g])
        );
    end

    // Enable and segments come from the same idx so they always switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit   <= '1;
            display <= 7'b1111111;
        end else begin
            digit   <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
            display <= seg_all[idx];
        end
    end
endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench for seven_segment_scan: stimulus queues expected displays, a monitor checks each commit.
module tb_seven_segment_scan;
    localparam int ND = 4;
    localparam int VW = 14;
    localparam int DB = 2;

    typedef struct packed {
        logic                ovf;
        logic [ND-1:0][6:0]  seg;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [VW-1:0] value = '0;
    logic          value_valid = 1'b0;
    logic          blank = 1'b0;
    logic          busy, overflow;
    logic [6:0]    display;
    logic [ND-1:0] digit;

    int   checks = 0, errors = 0, cyc = 0, n_pushed = 0, n_done = 0;
    exp_t sb[$];

    seven_segment_scan #(.NUM_DIGITS(ND), .VALUE_W(VW), .DIV_BITS(DB)) dut (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .blank(blank),
        .busy(busy), .overflow(overflow), .display(display), .digit(digit)
    );

    always #5 clk = ~clk;

    // Clocks since the last reset edge; the scan slot follows directly from it.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        int   p = 1;
        e.ovf = (v >= 10**ND);
        for (int i = 0; i < ND; i++) begin
            if (e.ovf) e.seg[i] = 7'b0111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            else if (i > 0 && v < p) e.seg[i] = 7'b1111111;
`endif
            else e.seg[i] = seg_of((v / p) % 10);
            p = p * 10;
        end
        return e;
    endfunction

    function automatic int scan_idx();
        return ((cyc - 1) / (1 << DB)) % ND;
    endfunction

    // Monitor: each busy fall is a commit (or reset abort); check overflow and a full scan.
    initial begin : monitor
        logic               bp;
        exp_t               e;
        logic [ND-1:0][6:0] got;
        logic [ND-1:0]      seen, dg, edg;
        bp = 1'b0;
        forever begin
            @(negedge clk);
            if (bp === 1'b1 && busy === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got 0 queued entries, required 1");
                end else begin
                    e = sb.pop_front();
                    chk("overflow", overflow, e.ovf);
                    seen = '0;
                    got  = '0;
                    @(negedge clk);
                    for (int k = 0; k < ND * (1 << DB); k++) begin
                        @(negedge clk);
                        dg  = digit;
                        edg = ~(ND'(1) << scan_idx());
                        chk("scan_digit", dg, edg);
                        for (int i = 0; i < ND; i++) begin
                            edg = ~(ND'(1) << i);
                            if (dg == edg) begin
                                got[i]  = display;
                                seen[i] = 1'b1;
                            end
                        end
                    end
                    for (int i = 0; i < ND; i++) begin
                        chk("digit_seen", seen[i], 1);
                        chk("digit_seg", got[i], e.seg[i]);
                    end
                end
                n_done++;
            end
            bp = busy;
        end
    end

    // kind: 0 plain, 1 extra valid (9999) mid-conversion, 2 reset mid-conversion.
    task automatic load(input int v, input int kind);
        int cnt;
        sb.push_back(model(kind == 2 ? 0 : v));
        n_pushed++;
        value       = VW'(v);
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (kind == 1 && cnt == 3) begin value = VW'(9999); value_valid = 1'b1; end
            if (kind == 2 && cnt == 7) rst = 1'b1;
            @(negedge clk);
            value_valid = 1'b0;
            rst         = 1'b0;
        end
        chk("busy_cycles", cnt, (kind == 2) ? 7 : VW);
        if (kind == 2) chk("busy_after_rst", busy, 0);
    endtask

    task automatic wait_mon();
        int t = 0;
        while (n_done != n_pushed && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("monitor_drain", n_done, n_pushed);
    endtask

    initial begin : stim
        logic [ND-1:0] dg, edg;
        exp_t          e;
        int            ix;

        repeat (3) @(negedge clk);
        chk("rst_digit", digit, 4'b1111);
        chk("rst_display", display, 7'b1111111);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_digit", digit, 4'b1110);
        chk("first_display", display, 7'b1000000);

        load(1234, 0);
        wait_mon();

        blank = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dg = digit;
            chk("blank_digit", dg, 4'b1111);
        end
        blank = 1'b0;
        @(negedge clk);
        ix  = scan_idx();
        e   = model(1234);
        dg  = digit;
        edg = ~(ND'(1) << ix);
        chk("unblank_digit", dg, edg);
        chk("unblank_display", display, e.seg[ix]);

        load(12345, 0);
        wait_mon();
        load(42, 0);
        wait_mon();
        load(5678, 1);
        wait_mon();
        load(8765, 2);
        wait_mon();

        for (int r = 0; r < 8; r++) begin
            load(int'($urandom_range(0, (1 << VW) - 1)), 0);
            wait_mon();
        end
        load(9999, 0);
        wait_mon();
        load(0, 0);
        wait_mon();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
